// File: rtl/sr_latch_writer.sv
// Write-side driver for an external gated SR latch: sequences S/R/en with
// setup, enable pulse and hold, then verifies the synchronized Q/Qb readback.
module sr_latch_writer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic lat_S,
    output logic lat_R,
    output logic lat_en,
    input  logic lat_Q,
    input  logic lat_Qb,
    output logic busy,
    output logic done,
    output logic err,
    output logic stored_q,
    output logic stored_vld
);

    localparam int unsigned MAX_AB = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CD = (HOLD_CYC > SYNC_STAGES) ? HOLD_CYC : SYNC_STAGES;
    localparam int unsigned MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        CHECK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            exp_q;
    logic [SYNC_STAGES-1:0] q_sync;
    logic [SYNC_STAGES-1:0] qb_sync;
    logic            sync_Q;
    logic            sync_Qb;
    logic            check_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync  <= '0;
            qb_sync <= '0;
        end else begin
            q_sync  <= {q_sync[SYNC_STAGES-2:0], lat_Q};
            qb_sync <= {qb_sync[SYNC_STAGES-2:0], lat_Qb};
        end
    end

    assign sync_Q  = q_sync[SYNC_STAGES-1];
    assign sync_Qb = qb_sync[SYNC_STAGES-1];

    // Evaluated on the edge leaving SETTLE, so done/err/stored_* are registered
    // and land together in the CHECK cycle.
    assign check_fail = (sync_Q != exp_q) || (sync_Q == sync_Qb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            exp_q      <= 1'b0;
            lat_S      <= 1'b0;
            lat_R      <= 1'b0;
            lat_en     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            stored_q   <= 1'b0;
            stored_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        exp_q     <= req_op;
                        lat_S     <= req_op;
                        lat_R     <= ~req_op;
                        lat_en    <= 1'b0;
                        cnt       <= CW'(SETUP_CYC - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= PULSE;
                        lat_en <= 1'b1;
                        cnt    <= CW'(PULSE_CYC - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        lat_en <= 1'b0;
                        cnt    <= CW'(HOLD_CYC - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= SETTLE;
                        lat_S <= 1'b0;
                        lat_R <= 1'b0;
                        cnt   <= CW'(SYNC_STAGES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                        cnt   <= '0;
                        done  <= 1'b1;
                        err   <= check_fail;
                        if (check_fail) begin
                            stored_vld <= 1'b0;
                        end else begin
                            stored_q   <= exp_q;
                            stored_vld <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    lat_S     <= 1'b0;
                    lat_R     <= 1'b0;
                    lat_en    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Bench for sr_latch_writer: default-parameter instance driven from a vector
// table plus corner sequences, and a second instance with a swept timing set.
module tb_sr_latch_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic v1, op1, rdy1, s1, r1, en1, q1, qb1, busy1, done1, err1, sq1, sv1;
    logic v2, op2, rdy2, s2, r2, en2, q2, qb2, busy2, done2, err2, sq2, sv2;

    sr_latch_writer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_op(op1), .req_ready(rdy1),
        .lat_S(s1), .lat_R(r1), .lat_en(en1), .lat_Q(q1), .lat_Qb(qb1),
        .busy(busy1), .done(done1), .err(err1), .stored_q(sq1), .stored_vld(sv1)
    );

    sr_latch_writer #(
        .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .SYNC_STAGES(3)
    ) dut_sw (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_op(op2), .req_ready(rdy2),
        .lat_S(s2), .lat_R(r2), .lat_en(en2), .lat_Q(q2), .lat_Qb(qb2),
        .busy(busy2), .done(done2), .err(err2), .stored_q(sq2), .stored_vld(sv2)
    );

    // Gated SR latch models; fault 1 = stuck Q=0/Qb=1, fault 2 = Q=Qb=1.
    logic mq1 = 1'b0;
    logic mq2 = 1'b0;
    int   fault = 0;
    always @(en1 or s1 or r1) if (en1) begin
        if (s1) mq1 = 1'b1;
        else if (r1) mq1 = 1'b0;
    end
    always @(en2 or s2 or r2) if (en2) begin
        if (s2) mq2 = 1'b1;
        else if (r2) mq2 = 1'b0;
    end
    assign q1  = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : mq1;
    assign qb1 = (fault == 1) ? 1'b1 : (fault == 2) ? 1'b1 : ~mq1;
    assign q2  = mq2;
    assign qb2 = ~mq2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Invariant monitors: S/R exclusive; S/R stable whenever en is high or toggles.
    logic ps1, pr1, pe1, pv1 = 1'b0;
    logic ps2, pr2, pe2, pv2 = 1'b0;
    always @(negedge clk) begin
        if (rst_n && pv1) begin
            chk("inv1_excl", {31'd0, s1 & r1}, 32'd0);
            if (en1 || (en1 != pe1)) chk("inv1_stable", {30'd0, s1, r1}, {30'd0, ps1, pr1});
        end
        if (rst_n && pv2) begin
            chk("inv2_excl", {31'd0, s2 & r2}, 32'd0);
            if (en2 || (en2 != pe2)) chk("inv2_stable", {30'd0, s2, r2}, {30'd0, ps2, pr2});
        end
        ps1 <= s1; pr1 <= r1; pe1 <= en1; pv1 <= rst_n;
        ps2 <= s2; pr2 <= r2; pe2 <= en2; pv2 <= rst_n;
    end

    task automatic get(input int w, output logic s, output logic r, output logic en,
                       output logic dn, output logic er, output logic rdy, output logic bz);
        if (w == 0) begin
            s = s1; r = r1; en = en1; dn = done1; er = err1; rdy = rdy1; bz = busy1;
        end else begin
            s = s2; r = r2; en = en2; dn = done2; er = err2; rdy = rdy2; bz = busy2;
        end
    endtask

    task automatic set_req(input int w, input logic v, input logic op);
        if (w == 0) begin v1 = v; op1 = op; end
        else begin v2 = v; op2 = op; end
    endtask

    // One command with cycle-by-cycle traces against a timing model built from the params.
    task automatic run_cmd(input int w, input logic op, input int su, input int pu,
                           input int ho, input int ss, input logic exp_err, input string nm);
        int n;
        logic s, r, en, dn, er, rdy, bz;
        logic [15:0] as, ar, ae, ad, aer, ardy, abz;
        logic [15:0] es, erv, ee, ed, eer, erdy, ebz;
        n = su + pu + ho + ss + 1;
        as = '0; ar = '0; ae = '0; ad = '0; aer = '0; ardy = '0; abz = '0;
        es = '0; erv = '0; ee = '0; ed = '0; eer = '0; erdy = '0; ebz = '0;
        @(negedge clk);
        get(w, s, r, en, dn, er, rdy, bz);
        chk({nm, "_ready_pre"}, {31'd0, rdy}, 32'd1);
        set_req(w, 1'b1, op);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1) set_req(w, 1'b0, op);
            get(w, s, r, en, dn, er, rdy, bz);
            as[k] = s; ar[k] = r; ae[k] = en; ad[k] = dn; aer[k] = er; ardy[k] = rdy; abz[k] = bz;
            es[k]   = (k <= su + pu + ho) ? op : 1'b0;
            erv[k]  = (k <= su + pu + ho) ? ~op : 1'b0;
            ee[k]   = (k > su) && (k <= su + pu);
            ed[k]   = (k == n);
            eer[k]  = (k == n) && exp_err;
            erdy[k] = (k > n);
            ebz[k]  = (k <= n);
        end
        chk({nm, "_S"},     {16'd0, as},   {16'd0, es});
        chk({nm, "_R"},     {16'd0, ar},   {16'd0, erv});
        chk({nm, "_en"},    {16'd0, ae},   {16'd0, ee});
        chk({nm, "_done"},  {16'd0, ad},   {16'd0, ed});
        chk({nm, "_err"},   {16'd0, aer},  {16'd0, eer});
        chk({nm, "_ready"}, {16'd0, ardy}, {16'd0, erdy});
        chk({nm, "_busy"},  {16'd0, abz},  {16'd0, ebz});
    endtask

    typedef struct {
        logic op;
        int   flt;
        logic e_err;
        logic e_sq;
        logic e_sv;
    } vec_t;

    vec_t tbl[6];
    logic ops[3];
    int   dcyc[3];
    int   nacc, ndone, bad_rdy, bad_post;

    initial begin
        tbl[0] = '{op: 1'b1, flt: 0, e_err: 1'b0, e_sq: 1'b1, e_sv: 1'b1};
        tbl[1] = '{op: 1'b0, flt: 0, e_err: 1'b0, e_sq: 1'b0, e_sv: 1'b1};
        tbl[2] = '{op: 1'b1, flt: 1, e_err: 1'b1, e_sq: 1'b0, e_sv: 1'b0};
        tbl[3] = '{op: 1'b0, flt: 2, e_err: 1'b1, e_sq: 1'b0, e_sv: 1'b0};
        tbl[4] = '{op: 1'b1, flt: 0, e_err: 1'b0, e_sq: 1'b1, e_sv: 1'b1};
        tbl[5] = '{op: 1'b0, flt: 2, e_err: 1'b1, e_sq: 1'b1, e_sv: 1'b0};
        ops[0] = 1'b1; ops[1] = 1'b0; ops[2] = 1'b1;

        rst_n = 1'b0;
        v1 = 1'b0; op1 = 1'b0; v2 = 1'b0; op2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_dut", {23'd0, rdy1, s1, r1, en1, busy1, done1, err1, sq1, sv1}, 32'h100);
        chk("reset_sw",  {23'd0, rdy2, s2, r2, en2, busy2, done2, err2, sq2, sv2}, 32'h100);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", {23'd0, rdy1, s1, r1, en1, busy1, done1, err1, sq1, sv1}, 32'h100);

        for (int i = 0; i < 6; i++) begin
            fault = tbl[i].flt;
            run_cmd(0, tbl[i].op, 1, 2, 1, 2, tbl[i].e_err, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_stored_q", i),   {31'd0, sq1}, {31'd0, tbl[i].e_sq});
            chk($sformatf("vec%0d_stored_vld", i), {31'd0, sv1}, {31'd0, tbl[i].e_sv});
            fault = 0;
        end

        // Back-to-back with req_valid held high.
        @(negedge clk);
        v1 = 1'b1; op1 = ops[0]; nacc = 1; ndone = 0; bad_rdy = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done1) begin
                if (ndone < 3) dcyc[ndone] = c;
                ndone++;
            end
            if (rdy1 == busy1) bad_rdy++;
            if (rdy1 && nacc < 3) begin
                op1 = ops[nacc];
                nacc++;
            end else if (!rdy1 && nacc == 3) begin
                v1 = 1'b0;
            end
        end
        chk("b2b_ndone", ndone, 3);
        chk("b2b_done0", dcyc[0], 7);
        chk("b2b_done1", dcyc[1], 15);
        chk("b2b_done2", dcyc[2], 23);
        chk("b2b_ready_vs_busy", bad_rdy, 0);
        chk("b2b_stored", {30'd0, sq1, sv1}, 32'd3);

        // Asynchronous reset in the middle of the enable pulse.
        @(negedge clk);
        v1 = 1'b1; op1 = 1'b0;
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        chk("mid_en_before", {31'd0, en1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_outputs_async", {29'd0, en1, s1, r1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_post = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done1 || !rdy1 || busy1 || sv1) bad_post++;
        end
        chk("mid_after_release", bad_post, 0);

        // Swept timing on the second instance: done at cycle 10.
        run_cmd(1, 1'b1, 3, 1, 2, 3, 1'b0, "sw_set");
        chk("sw_set_stored", {30'd0, sq2, sv2}, 32'd3);
        run_cmd(1, 1'b0, 3, 1, 2, 3, 1'b0, "sw_rst");
        chk("sw_rst_stored", {30'd0, sq2, sv2}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_writer.md
Name: sr_latch_writer

Overview:
- Synchronous controller that writes one bit into an external gated SR latch: S/R data inputs and an active-high enable.
- Takes set/reset commands on a valid/ready handshake and generates a glitch-free S/R/en sequence: setup, enable pulse, hold.
- Synchronizes the latch's Q/Qb back into the clock domain and checks the written value, reporting done/err.
- Acts as the write-side driver for latch-based storage bits.

Parameters:
- SETUP_CYC, 1, cycles S/R are driven stable with en=0 before the enable pulse (>=1)
- PULSE_CYC, 2, cycles lat_en is held high (>=1)
- HOLD_CYC, 1, cycles S/R are held after lat_en falls (>=1)
- SYNC_STAGES, 2, flop stages on lat_Q/lat_Qb readback (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  command request
- req_op  input  1  1 = set (expect Q=1), 0 = reset (expect Q=0); sampled on accept
- req_ready  output  1  high only in IDLE
- lat_S  output  1  latch set input, registered
- lat_R  output  1  latch reset input, registered
- lat_en  output  1  latch enable, registered
- lat_Q  input  1  latch Q, asynchronous to clk
- lat_Qb  input  1  latch Qb, asynchronous to clk
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of every command
- err  output  1  one-cycle pulse coincident with done on readback failure
- stored_q  output  1  last successfully verified latch value
- stored_vld  output  1  stored_q is valid

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 and on release:
  - all outputs are 0 except req_ready=1
  - FSM is in IDLE
  - all counters and synchronizer flops are 0
- Reset mid-operation: lat_en, lat_S and lat_R drop to 0 immediately. Latch content is undefined to this block, so stored_vld=0.
- Accept: req_valid && req_ready at a rising edge. req_op is captured into exp_q. req_valid without req_ready is ignored; there is no queueing.
- FSM states: IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK. Every state other than IDLE lasts a fixed count of cycles from a shared down-counter:
  - IDLE: lat_S=lat_R=lat_en=0. On accept -> SETUP.
  - SETUP (SETUP_CYC cycles): lat_S=exp_q, lat_R=~exp_q, lat_en=0.
  - PULSE (PULSE_CYC cycles): S/R unchanged, lat_en=1.
  - HOLD (HOLD_CYC cycles): S/R unchanged, lat_en=0.
  - SETTLE (SYNC_STAGES cycles): lat_S=lat_R=lat_en=0. Readback is propagating through the synchronizer.
  - CHECK (1 cycle): done=1. err=1 if sync_Q!=exp_q or sync_Q==sync_Qb. Then -> IDLE.
- Latency: done is high in cycle N after the accept edge, where N = SETUP_CYC+PULSE_CYC+HOLD_CYC+SYNC_STAGES+1. Defaults give N=7.
- Invariants (must hold in every cycle):
  - lat_S and lat_R are never both 1.
  - S/R never change in a cycle where lat_en=1.
  - lat_en changes only with S/R already stable for at least one cycle.
- Result update in CHECK:
  - pass: stored_q<=exp_q, stored_vld<=1
  - fail: stored_vld<=0, stored_q unchanged
- Back-to-back commands: req_ready returns high in the cycle after CHECK. With req_valid held high, the next accept occurs 1 cycle after done, giving a command period of N+1.
- Readback: lat_Q and lat_Qb each pass through SYNC_STAGES flops. Only the final stage is used.

Test Plan:
- Set with defaults: pulse req_valid, req_op=1; latch model follows. Required:
  - lat_S=1 on cycles 1-4; lat_en=1 on cycles 2-3 only.
  - done=1 at cycle 7, err=0; stored_q=1, stored_vld=1.
- Reset after set: req_op=0. Required:
  - lat_R=1 and lat_S=0 on cycles 1-4.
  - done at cycle 7, err=0; stored_q=0.
- Back-to-back: req_valid=1 for 3 commands (1,0,1). Required:
  - accepts 8 cycles apart; done at cycles 7, 15, 23.
  - final stored_q=1; req_ready=0 throughout each busy period.
- Stuck-at fault: force lat_Q=0, lat_Qb=1 during a set command. Required: done and err both high at cycle 7; stored_vld=0.
- Invalid latch state: force lat_Q=lat_Qb=1 during a reset command. Required: err=1 at cycle 7.
- Reset mid-PULSE: assert rst_n=0 asynchronously at cycle 2.5. Required:
  - lat_en=0 within the same cycle, before the next clock edge.
  - after release: req_ready=1, busy=0, stored_vld=0, no done pulse.
- Parameter sweep: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, SYNC_STAGES=3. Required: done at cycle 10; the S/R exclusivity and en-stability invariants hold every cycle.
